dpd_capture_buffer: RTL and testbench



---
 rtl/dpd_capture_pkg.sv | 28 ++
 rtl/capture_ram.sv | 44 ++++
 rtl/dpd_capture_buffer.sv | 141 ++++++++++++++
 tb/tb_dpd_capture_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpd_capture_pkg.sv
// Shared types and lane-unpacking helpers for the DPD capture buffer.
package dpd_capture_pkg;

  localparam int unsigned SAMPLES_PER_WORD = 4;
  localparam int unsigned SAMPLE_W         = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StDone
  } capture_state_t;

  // Each 16-bit sample is split into a high byte and a low byte in separate 32-bit lanes.
  function automatic logic [SAMPLE_W-1:0] unpack_i(input logic [127:0] word, input int unsigned k);
    return {word[8*k +: 8], word[32+8*k +: 8]};
  endfunction

  function automatic logic [SAMPLE_W-1:0] unpack_q(input logic [127:0] word, input int unsigned k);
    return {word[64+8*k +: 8], word[96+8*k +: 8]};
  endfunction

  // The sign bit and the next bit disagree when the DPD output has clipped.
  function automatic logic sat_flag(input logic [SAMPLE_W-1:0] sample);
    return sample[SAMPLE_W-1] ^ sample[SAMPLE_W-2];
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture memory: single clock, read-first, registered read port.
module capture_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Non-blocking update of mem gives read-first behaviour on an address collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= mem[rd_addr_i];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/dpd_capture_buffer.sv
// Arm/trigger snapshot buffer for lane-packed DPD output words.
// Define DPD_CAPTURE_OVF_CNT_EN to add the saturated-sample counter (ovf_cnt_o).
module dpd_capture_buffer
  import dpd_capture_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              JESD_clk_i,
  input  logic              reset_n_i,
  input  logic [127:0]      data_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trigger_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   wr_count_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [127:0]      rd_data_o,
`ifdef DPD_CAPTURE_OVF_CNT_EN
  output logic [ADDR_W+2:0] ovf_cnt_o,
`endif
  output logic              rd_valid_o
);

  localparam logic [ADDR_W:0] LenMax = (ADDR_W+1)'(DEPTH);

  capture_state_t  state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wr_count_q, wr_count_d;
  logic [127:0]    data_q;
  logic            wr_en;
  logic            arm_accept;

  always_ff @(posedge JESD_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      len_q      <= LenMax;
      wr_count_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_count_q <= wr_count_d;
      data_q     <= data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_count_d = wr_count_q;
    wr_en      = 1'b0;
    arm_accept = 1'b0;
    if (abort_i) begin
      // Abort freezes wr_count and suppresses the write of the current cycle.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (arm_i) begin
            state_d    = StArmed;
            arm_accept = 1'b1;
            wr_count_d = '0;
            len_d      = ((len_i == '0) || (len_i > LenMax)) ? LenMax : len_i;
          end
        end
        StArmed: begin
          if (trigger_i) begin
            state_d = StCapture;
          end
        end
        StCapture: begin
          wr_en      = 1'b1;
          wr_count_d = wr_count_q + 1'b1;
          if (wr_count_d == len_q) begin
            state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign busy_o     = (state_q == StArmed) || (state_q == StCapture);
  assign done_o     = (state_q == StDone);
  assign wr_count_o = wr_count_q;

  capture_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (128)
  ) u_ram (
    .clk_i      (JESD_clk_i),
    .rst_ni     (reset_n_i),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_count_q[ADDR_W-1:0]),
    .wr_data_i  (data_q),
    .rd_en_i    (rd_en_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o)
  );

`ifdef DPD_CAPTURE_OVF_CNT_EN
  logic [ADDR_W+2:0] ovf_cnt_q, ovf_cnt_d;
  logic [3:0]        sat_n;
  logic [ADDR_W+3:0] ovf_sum;

  always_comb begin
    sat_n = '0;
    for (int unsigned k = 0; k < SAMPLES_PER_WORD; k++) begin
      sat_n = sat_n + {3'b000, sat_flag(unpack_i(data_q, k))}
                    + {3'b000, sat_flag(unpack_q(data_q, k))};
    end
  end

  always_comb begin
    ovf_sum   = {1'b0, ovf_cnt_q} + (ADDR_W+4)'(sat_n);
    ovf_cnt_d = ovf_cnt_q;
    if (arm_accept) begin
      ovf_cnt_d = '0;
    end else if (wr_en) begin
      ovf_cnt_d = ovf_sum[ADDR_W+3] ? '1 : ovf_sum[ADDR_W+2:0];
    end
  end

  always_ff @(posedge JESD_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_dpd_capture_buffer.sv
// Directed self-checking bench for dpd_capture_buffer (default DEPTH = 1024).
module tb_dpd_capture_buffer;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              reset_n;
  logic [127:0]      data_i;
  logic              arm_i;
  logic              abort_i;
  logic              trigger_i;
  logic [ADDR_W:0]   len_i;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   wr_count_o;
  logic              rd_en_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [127:0]      rd_data_o;
  logic              rd_valid_o;
`ifdef DPD_CAPTURE_OVF_CNT_EN
  logic [ADDR_W+2:0] ovf_cnt_o;
`endif

  int checks;
  int errors;

  dpd_capture_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .JESD_clk_i (clk),
    .reset_n_i  (reset_n),
    .data_i     (data_i),
    .arm_i      (arm_i),
    .abort_i    (abort_i),
    .trigger_i  (trigger_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .wr_count_o (wr_count_o),
    .rd_en_i    (rd_en_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
`ifdef DPD_CAPTURE_OVF_CNT_EN
    .ovf_cnt_o  (ovf_cnt_o),
`endif
    .rd_valid_o (rd_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input int v);
    logic [31:0] x;
    x = v;
    return {32'hA5A5_0000 ^ x, 32'h5A5A_0000 ^ x, ~x, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm with len, trigger with word base+0; afterwards the DUT is in CAPTURE at wr_count 0.
  task automatic start_capture(input int len, input int base);
    arm_i = 1'b1;
    len_i = (ADDR_W+1)'(len);
    data_i = mk(base);
    tick();
    arm_i = 1'b0;
    trigger_i = 1'b1;
    data_i = mk(base);
    tick();
    trigger_i = 1'b0;
  endtask

  task automatic run_words(input int first, input int n, input int base);
    for (int j = 0; j < n; j++) begin
      data_i = mk(base + first + j + 1);
      tick();
    end
  endtask

  task automatic do_read(input int addr);
    rd_en_i = 1'b1;
    rd_addr_i = ADDR_W'(addr);
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || wr_count_o !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b wr_count=%0d, required 0 0 0",
               busy_o, done_o, wr_count_o);
    end
    checks++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== '0) begin
      errors++;
      $display("FAIL reset_rd: rd_valid=%b rd_data=%h, required 0 and 0", rd_valid_o, rd_data_o);
    end
`ifdef DPD_CAPTURE_OVF_CNT_EN
    checks++;
    if (ovf_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_ovf: ovf_cnt=%0d, required 0", ovf_cnt_o);
    end
`endif
  endtask

  task automatic test_basic_capture();
    start_capture(8, 0);
    checks++;
    if (busy_o !== 1'b1 || wr_count_o !== 11'd0) begin
      errors++;
      $display("FAIL basic_start: busy=%b wr_count=%0d, required 1 0", busy_o, wr_count_o);
    end
    for (int j = 0; j < 7; j++) begin
      run_words(j, 1, 0);
      checks++;
      if (done_o !== 1'b0 || wr_count_o !== 11'(j + 1)) begin
        errors++;
        $display("FAIL basic_progress: done=%b wr_count=%0d, required 0 %0d",
                 done_o, wr_count_o, j + 1);
      end
    end
    run_words(7, 1, 0);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || wr_count_o !== 11'd8) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b wr_count=%0d, required 1 0 8",
               done_o, busy_o, wr_count_o);
    end
    for (int a = 0; a < 8; a++) begin
      do_read(a);
      checks++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== mk(a)) begin
        errors++;
        $display("FAIL basic_read: addr=%0d valid=%b data=%h, required 1 %h",
                 a, rd_valid_o, rd_data_o, mk(a));
      end
    end
    tick();
    checks++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== mk(7)) begin
      errors++;
      $display("FAIL read_hold: valid=%b data=%h, required 0 %h", rd_valid_o, rd_data_o, mk(7));
    end
  endtask

  task automatic clamp_run(input int len, input int base);
    start_capture(len, base);
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0 || wr_count_o !== 11'd0) begin
      errors++;
      $display("FAIL clamp_arm len=%0d: busy=%b done=%b wr_count=%0d, required 1 0 0",
               len, busy_o, done_o, wr_count_o);
    end
    run_words(0, 1023, base);
    checks++;
    if (done_o !== 1'b0 || wr_count_o !== 11'd1023) begin
      errors++;
      $display("FAIL clamp_1023 len=%0d: done=%b wr_count=%0d, required 0 1023",
               len, done_o, wr_count_o);
    end
    run_words(1023, 1, base);
    checks++;
    if (done_o !== 1'b1 || wr_count_o !== 11'd1024) begin
      errors++;
      $display("FAIL clamp_done len=%0d: done=%b wr_count=%0d, required 1 1024",
               len, done_o, wr_count_o);
    end
    do_read(1023);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== mk(base + 1023)) begin
      errors++;
      $display("FAIL clamp_read1023 len=%0d: valid=%b data=%h, required 1 %h",
               len, rd_valid_o, rd_data_o, mk(base + 1023));
    end
    do_read(0);
    checks++;
    if (rd_data_o !== mk(base)) begin
      errors++;
      $display("FAIL clamp_read0 len=%0d: data=%h, required %h", len, rd_data_o, mk(base));
    end
  endtask

  task automatic test_length_clamp();
    clamp_run(0, 1000);
    clamp_run(DEPTH + 1, 3000);
  endtask

  task automatic test_abort();
    start_capture(8, 5000);
    run_words(0, 3, 5000);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || wr_count_o !== 11'd3) begin
      errors++;
      $display("FAIL abort_capture: busy=%b done=%b wr_count=%0d, required 0 0 3",
               busy_o, done_o, wr_count_o);
    end
    abort_i = 1'b1;
    arm_i = 1'b1;
    len_i = 11'd4;
    tick();
    abort_i = 1'b0;
    arm_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || wr_count_o !== 11'd3) begin
      errors++;
      $display("FAIL abort_over_arm: busy=%b wr_count=%0d, required 0 3", busy_o, wr_count_o);
    end
  endtask

  task automatic test_gating();
    trigger_i = 1'b1;
    tick();
    tick();
    trigger_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || wr_count_o !== 11'd3) begin
      errors++;
      $display("FAIL trig_idle: busy=%b wr_count=%0d, required 0 3", busy_o, wr_count_o);
    end
    start_capture(4, 6000);
    run_words(0, 1, 6000);
    arm_i = 1'b1;
    len_i = 11'd8;
    data_i = mk(6002);
    tick();
    arm_i = 1'b0;
    run_words(2, 1, 6000);
    checks++;
    if (done_o !== 1'b0 || wr_count_o !== 11'd3) begin
      errors++;
      $display("FAIL rearm_mid: done=%b wr_count=%0d, required 0 3", done_o, wr_count_o);
    end
    run_words(3, 1, 6000);
    checks++;
    if (done_o !== 1'b1 || wr_count_o !== 11'd4) begin
      errors++;
      $display("FAIL rearm_ignored: done=%b wr_count=%0d, required 1 4", done_o, wr_count_o);
    end
    trigger_i = 1'b1;
    data_i = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
    tick();
    tick();
    trigger_i = 1'b0;
    tick();
    checks++;
    if (done_o !== 1'b1 || wr_count_o !== 11'd4) begin
      errors++;
      $display("FAIL trig_done: done=%b wr_count=%0d, required 1 4", done_o, wr_count_o);
    end
    do_read(4);
    checks++;
    if (rd_data_o !== mk(3004)) begin
      errors++;
      $display("FAIL stale_addr4: data=%h, required %h", rd_data_o, mk(3004));
    end
    do_read(3);
    checks++;
    if (rd_data_o !== mk(6003)) begin
      errors++;
      $display("FAIL short_addr3: data=%h, required %h", rd_data_o, mk(6003));
    end
  endtask

  task automatic test_reset_mid_capture();
    start_capture(16, 7000);
    run_words(0, 5, 7000);
    checks++;
    if (wr_count_o !== 11'd5 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: busy=%b wr_count=%0d, required 1 5", busy_o, wr_count_o);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || wr_count_o !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b wr_count=%0d, required 0 0 0",
               busy_o, done_o, wr_count_o);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || wr_count_o !== '0) begin
      errors++;
      $display("FAIL post_reset: busy=%b wr_count=%0d, required 0 0", busy_o, wr_count_o);
    end
  endtask

`ifdef DPD_CAPTURE_OVF_CNT_EN
  task automatic test_ovf_cnt();
    arm_i = 1'b1;
    len_i = 11'd4;
    tick();
    arm_i = 1'b0;
    trigger_i = 1'b1;
    // I_0 = 0x4000, Q_3 = 0xBFFF, every other sample 0.
    data_i = 128'hFF00_0000_BF00_0000_0000_0000_0000_0040;
    tick();
    trigger_i = 1'b0;
    repeat (4) tick();
    checks++;
    if (done_o !== 1'b1 || ovf_cnt_o !== 13'd8) begin
      errors++;
      $display("FAIL ovf_count: done=%b ovf_cnt=%0d, required 1 8", done_o, ovf_cnt_o);
    end
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    checks++;
    if (ovf_cnt_o !== '0) begin
      errors++;
      $display("FAIL ovf_clear: ovf_cnt=%0d, required 0", ovf_cnt_o);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    data_i    = '0;
    arm_i     = 1'b0;
    abort_i   = 1'b0;
    trigger_i = 1'b0;
    len_i     = '0;
    rd_en_i   = 1'b0;
    rd_addr_i = '0;
    repeat (3) tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_basic_capture();
    test_length_clamp();
    test_abort();
    test_gating();
    test_reset_mid_capture();
`ifdef DPD_CAPTURE_OVF_CNT_EN
    test_ovf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
